// File: rtl/sound_mixer.sv
// Multi-channel sound mixer: snapshots channel samples on each sample tick, applies per-channel
// volume through one shared multiplier, saturates the sum and applies a click-free master gain ramp.
module sound_mixer #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned IN_W      = 16,
  parameter int unsigned VOL_W     = 4,
  parameter int unsigned DIV       = 64,
  parameter int unsigned RAMP_STEP = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_3MHz_en,
  input  logic [NUM_CH*IN_W-1:0]   ch_in,
  input  logic [NUM_CH*VOL_W-1:0]  ch_vol,
  input  logic                     sound_en,
  output logic [15:0]              out,
  output logic                     out_valid,
  output logic                     overrun
);

  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W   = $clog2(NUM_CH);
  localparam int unsigned ACC_W   = IN_W + IDX_W + 1;
  localparam int unsigned PROD_W  = IN_W + VOL_W;
  localparam int unsigned GAIN_W  = 9;
  localparam int unsigned GAIN_W1 = GAIN_W + 1;
  localparam int unsigned SCL_W   = 25;
  localparam logic [GAIN_W-1:0] GAIN_MAX = 9'd256;

  typedef enum logic [1:0] {IDLE, ACCUM, SAT, SCALE} state_t;

  state_t             state;
  logic [DIV_W-1:0]   divider;
  logic [IDX_W-1:0]   idx;
  logic [ACC_W-1:0]   acc;
  logic [15:0]        sat;
  logic [GAIN_W-1:0]  gain;
  logic [IN_W-1:0]    snap_in  [NUM_CH];
  logic [VOL_W-1:0]   snap_vol [NUM_CH];

  logic               tick;
  logic [PROD_W-1:0]  prod;
  logic [IN_W-1:0]    contrib;
  logic [SCL_W-1:0]   scaled;
  logic [GAIN_W1-1:0] gain_up;
  logic [GAIN_W-1:0]  gain_next;

  assign tick    = clk_3MHz_en && (divider == DIV_W'(DIV - 1));

  // Shared multiplier: one channel per cycle while accumulating.
  assign prod    = PROD_W'(snap_in[idx]) * PROD_W'(snap_vol[idx]);
  assign contrib = IN_W'(prod >> VOL_W);
  assign scaled  = SCL_W'(sat) * SCL_W'(gain);

  // Gain ramps toward 256 or 0 by RAMP_STEP, clamped at both ends.
  assign gain_up   = {1'b0, gain} + GAIN_W1'(RAMP_STEP);
  assign gain_next = sound_en
                   ? ((gain_up > GAIN_W1'(GAIN_MAX)) ? GAIN_MAX : gain_up[GAIN_W-1:0])
                   : ((gain > GAIN_W'(RAMP_STEP)) ? gain - GAIN_W'(RAMP_STEP) : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      divider   <= '0;
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      sat       <= '0;
      gain      <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (clk_3MHz_en) divider <= tick ? '0 : divider + DIV_W'(1);
      // Any tick outside IDLE (including the SCALE cycle) is dropped and flagged.
      if (tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (tick) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
              snap_in[i]  <= ch_in[i*IN_W +: IN_W];
              snap_vol[i] <= ch_vol[i*VOL_W +: VOL_W];
            end
            acc   <= '0;
            idx   <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc + ACC_W'(contrib);
          if (idx == IDX_W'(NUM_CH - 1)) state <= SAT;
          else                           idx   <= idx + IDX_W'(1);
        end
        SAT: begin
          sat   <= (acc > ACC_W'(65535)) ? 16'hFFFF : acc[15:0];
          state <= SCALE;
        end
        SCALE: begin
          out       <= 16'(scaled >> 8);
          out_valid <= 1'b1;
          gain      <= gain_next;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sound_mixer.sv
// Self-checking bench for sound_mixer: a pending-sample/deadline model checked every cycle,
// plus literal expectations for ramp, saturation, overrun and mid-sample reset.
module tb_sound_mixer;

  logic        clk = 1'b0;
  logic        rst, en_a, en_b, sound_en;
  logic [63:0] ch_in;
  logic [15:0] ch_vol;
  logic [15:0] out_a, out_b;
  logic        val_a, val_b, ovr_a, ovr_b;

  always #5 clk = ~clk;

  sound_mixer #(.NUM_CH(4), .IN_W(16), .VOL_W(4), .DIV(16), .RAMP_STEP(16)) dut_a (
    .clk(clk), .rst(rst), .clk_3MHz_en(en_a), .ch_in(ch_in), .ch_vol(ch_vol),
    .sound_en(sound_en), .out(out_a), .out_valid(val_a), .overrun(ovr_a));

  sound_mixer #(.NUM_CH(4), .IN_W(16), .VOL_W(4), .DIV(1), .RAMP_STEP(16)) dut_b (
    .clk(clk), .rst(rst), .clk_3MHz_en(en_b), .ch_in(ch_in), .ch_vol(ch_vol),
    .sound_en(sound_en), .out(out_b), .out_valid(val_b), .overrun(ovr_b));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a sample is a pending item with a deadline edge; the gain is applied at the deadline.
  typedef struct {
    int unsigned cnt;
    int unsigned gain;
    bit          pend;
    int unsigned pend_sat;
    longint      edge_n;
    longint      due;
    bit [15:0]   out;
    bit          valid;
    bit          ovr;
  } mdl_t;

  function automatic mdl_t mstep(input mdl_t s, input int unsigned div, input bit r, input bit en,
                                 input bit se, input logic [63:0] ci, input logic [15:0] cv);
    mdl_t        n;
    bit          tick;
    int unsigned sum;
    n        = s;
    n.edge_n = s.edge_n + 1;
    n.valid  = 1'b0;
    if (r) begin
      n.cnt = 0; n.gain = 0; n.pend = 1'b0; n.out = '0; n.ovr = 1'b0;
      return n;
    end
    if (s.pend && n.edge_n == s.due) begin
      n.out   = 16'((s.pend_sat * s.gain) >> 8);
      n.valid = 1'b1;
      if (se) n.gain = (s.gain + 16 > 256) ? 256 : s.gain + 16;
      else    n.gain = (s.gain > 16) ? s.gain - 16 : 0;
      n.pend  = 1'b0;
    end
    if (en) begin
      tick  = (s.cnt == div - 1);
      n.cnt = tick ? 0 : s.cnt + 1;
      if (tick) begin
        if (s.pend) n.ovr = 1'b1;
        else begin
          sum = 0;
          for (int i = 0; i < 4; i++)
            sum += (int'(ci[i*16 +: 16]) * int'(cv[i*4 +: 4])) >> 4;
          n.pend     = 1'b1;
          n.pend_sat = (sum > 65535) ? 65535 : sum;
          n.due      = n.edge_n + 6;
        end
      end
    end
    return n;
  endfunction

  mdl_t ma = '{default: 0};
  mdl_t mb = '{default: 0};
  bit   cmp_en = 1'b0;

  always @(posedge clk) begin
    ma = mstep(ma, 16, rst, en_a, sound_en, ch_in, ch_vol);
    mb = mstep(mb, 1,  rst, en_b, sound_en, ch_in, ch_vol);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("a_valid", 32'(val_a), 32'(ma.valid));
      check("a_out",   32'(out_a), 32'(ma.out));
      check("a_ovr",   32'(ovr_a), 32'(ma.ovr));
      check("b_valid", 32'(val_b), 32'(mb.valid));
      check("b_out",   32'(out_b), 32'(mb.out));
      check("b_ovr",   32'(ovr_b), 32'(mb.ovr));
    end
  end

  int cyc  = 0;
  int mode = 1;
  bit en_b_on = 1'b0;

  task automatic step();
    @(negedge clk);
    cyc++;
    if (mode == 0) en_a = (cyc % 4 == 0);
    else           en_a = ($urandom_range(0, 3) == 0);
    en_b = en_b_on;
  endtask

  task automatic wait_sample(output logic [15:0] v);
    int n = 0;
    do begin
      step();
      n++;
    end while (!val_a && n < 200);
    if (!val_a) begin
      checks++;
      failures++;
      $display("FAIL sample_timeout: got no out_valid expected a pulse within 200 cycles");
    end
    v = out_a;
  endtask

  logic [15:0] samp [1:20];
  logic [15:0] v;
  int          t0, t1, npulse;

  initial begin
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0; sound_en = 1'b1;
    ch_in = {$urandom, $urandom}; ch_vol = 16'($urandom);
    @(negedge clk);
    cmp_en = 1'b1;
    repeat (2) begin
      step();
      ch_in = {$urandom, $urandom}; ch_vol = 16'($urandom); sound_en = 1'($urandom);
    end
    check("rst_out", 32'(out_a), 32'h0);
    check("rst_valid", 32'(val_a), 32'h0);
    check("rst_ovr", 32'(ovr_a), 32'h0);

    // Ramp-up with ch0 = 0x8000 at full volume.
    rst = 1'b0; mode = 0; en_b_on = 1'b1; sound_en = 1'b1;
    ch_in = 64'h8000; ch_vol = 16'h000F;
    for (int k = 1; k <= 20; k++) begin
      wait_sample(v);
      samp[k] = v;
    end
    check("ramp_s1", 32'(samp[1]), 32'h0000);
    check("ramp_s2", 32'(samp[2]), 32'h0780);
    check("ramp_s16", 32'(samp[16]), 32'h7080);
    check("ramp_s17", 32'(samp[17]), 32'h7800);
    check("ramp_s20", 32'(samp[20]), 32'h7800);

    // Saturation at full gain.
    ch_in = '1; ch_vol = 16'hFFFF;
    wait_sample(v);
    wait_sample(v);
    check("sat_out", 32'(v), 32'hFFFF);

    // Mute ramp-down from steady state.
    ch_in = 64'h8000; ch_vol = 16'h000F;
    wait_sample(v);
    check("steady", 32'(v), 32'h7800);
    sound_en = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      wait_sample(v);
      samp[(k > 20) ? 20 : k] = v;
    end
    check("down_s1", 32'(samp[1]), 32'h7800);
    check("down_s2", 32'(samp[2]), 32'h7080);
    check("down_s16", 32'(samp[16]), 32'h0780);
    check("down_s17", 32'(samp[17]), 32'h0000);
    check("down_s18", 32'(samp[18]), 32'h0000);
    check("a_no_overrun", 32'(ovr_a), 32'h0);

    // Overrun instance: continuous ticks, dropped while busy, 7-cycle spacing.
    check("b_overrun", 32'(ovr_b), 32'h1);
    t0 = 0; t1 = 0;
    for (int n = 0; n < 20 && !val_b; n++) step();
    t0 = cyc;
    step();
    for (int n = 0; n < 20 && !val_b; n++) step();
    t1 = cyc;
    check("b_spacing", 32'(t1 - t0), 32'd7);

    // Randomized traffic: inputs change every cycle, occasional saturating mixes and mute toggles.
    mode = 1;
    for (int n = 0; n < 2000; n++) begin
      step();
      if ($urandom_range(0, 9) == 0) begin
        ch_in = '1; ch_vol = 16'hFFFF;
      end else begin
        ch_in = {$urandom, $urandom}; ch_vol = 16'($urandom);
      end
      if ($urandom_range(0, 49) == 0) sound_en = ~sound_en;
      en_b_on = 1'($urandom);
    end

    // Reset during accumulation: the sample is abandoned and gain restarts from zero.
    mode = 0; en_b_on = 1'b1; sound_en = 1'b1;
    ch_in = 64'h8000; ch_vol = 16'h000F;
    repeat (3) wait_sample(v);
    for (int n = 0; n < 200 && !ma.pend; n++) step();
    check("pend_seen", 32'(ma.pend), 32'h1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    npulse = 0;
    repeat (12) begin
      step();
      if (val_a) npulse++;
    end
    check("rst_mid_no_valid", 32'(npulse), 32'h0);
    check("rst_mid_out", 32'(out_a), 32'h0);
    check("rst_mid_ovr", 32'(ovr_a), 32'h0);
    wait_sample(v);
    check("post_rst_s1", 32'(v), 32'h0000);
    wait_sample(v);
    check("post_rst_s2", 32'(v), 32'h0780);

    repeat (4) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sound_mixer.md
Name: sound_mixer

Overview:
- Downstream stage of the engine sound generator and the other discrete-sound emulations.
- Snapshots NUM_CH unsigned 16-bit channel samples at a fixed sample rate derived from clk_3MHz_en.
- Scales each channel by a per-channel volume, sums them, saturates the sum, applies a master mute gain ramp (click-free on/off), and emits one 16-bit sample with a valid strobe.
- Uses a single time-multiplexed multiplier, one channel per clk cycle.

Parameters:
- NUM_CH, 4, number of input channels (2..8).
- IN_W, 16, channel sample width, unsigned.
- VOL_W, 4, per-channel volume width; scale factor = vol/2^VOL_W.
- DIV, 64, clk_3MHz_en pulses per output sample (46.875 kHz at default).
- RAMP_STEP, 16, master gain change per sample tick.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- clk_3MHz_en  in  1  3 MHz clock enable; at most one pulse per clk cycle.
- ch_in  in  NUM_CH*IN_W  packed samples; channel i = bits [i*IN_W +: IN_W].
- ch_vol  in  NUM_CH*VOL_W  packed volumes, same packing as ch_in.
- sound_en  in  1  master sound enable; ramp target is 256 when 1, 0 when 0.
- out  out  16  mixed sample, unsigned.
- out_valid  out  1  one-cycle pulse when out updates.
- overrun  out  1  sticky; set when a tick arrives while the mixer is busy.

Reset and clocking:
- Reset rst, synchronous, active-high; clock clk.
- Reset state: out=0, out_valid=0, overrun=0, gain=0, divider=0, state IDLE, acc=0.
- rst dominates everything, including mid-operation. An in-flight sample is abandoned and no out_valid is issued.

Tick generation:
- Divider counts clk_3MHz_en pulses 0..DIV-1.
- tick = clk_3MHz_en && divider==DIV-1; divider wraps to 0 on that cycle.

State machine: IDLE -> ACCUM -> SAT -> SCALE -> IDLE.
- IDLE, tick at cycle T:
  - Snapshot ch_in and ch_vol into internal registers.
  - acc<=0, idx<=0; go to ACCUM.
- ACCUM, cycles T+1..T+NUM_CH:
  - acc += (snap_in[idx]*snap_vol[idx]) >> VOL_W.
  - acc width IN_W + ceil(log2(NUM_CH)) + 1; never wraps.
  - idx increments; after idx==NUM_CH-1, go to SAT.
- SAT, cycle T+NUM_CH+1:
  - sat <= (acc > 65535) ? 65535 : acc[15:0].
- SCALE, cycle T+NUM_CH+2:
  - out <= (sat*gain) >> 8, 25-bit product, using the gain value before this cycle's update.
  - out_valid <= 1 (high exactly during cycle T+NUM_CH+3).
  - Gain update: sound_en ? min(gain+RAMP_STEP, 256) : max(gain-RAMP_STEP, 0). Gain is 9 bits.
  - Go to IDLE.
- Latency: tick to out_valid high = NUM_CH+3 clk cycles. Busy window = NUM_CH+2 cycles (T+1..T+NUM_CH+2).

Boundary conditions:
- Tick while not in IDLE: ignored (the in-flight sample completes unchanged); overrun<=1 and holds until rst.
- A tick in the same cycle the FSM returns to IDLE (SCALE cycle) counts as busy.
- vol=0 contributes 0. vol=2^VOL_W-1 contributes 15/16 of full scale at default VOL_W.
- Inputs changing during ACCUM have no effect on the current sample (snapshot rule).
- out holds its value between out_valid pulses.
- gain is updated only in SCALE, never on ticks or sound_en edges directly.

Test Plan:
- Reset check: assert rst 3 cycles with random inputs -> out=0, out_valid=0, overrun=0; first sample after tick is 0 because gain=0.
- Latency and ramp: NUM_CH=4, DIV=16, clk_3MHz_en every 4th clk, sound_en=1, ch0=0x8000 vol 15, others 0.
  - out_valid exactly 7 clk after each tick.
  - out sequence 0x0000, 0x0780, 0x0F00, ..., reaching a steady 0x7800 from the 17th sample.
- Saturation: all channels 0xFFFF vol 15, gain at 256 -> per-channel 0xEFFF, acc=0x3BFFC, out=0xFFFF.
- Mute ramp-down: from steady 0x7800, drop sound_en -> out decreases by 0x0780 per sample, reaching 0x0000 at the 17th sample after the drop and staying 0; overrun remains 0.
- Overrun: DIV=1, clk_3MHz_en every clk -> ticks during busy are ignored, overrun=1 and sticky; out_valid spacing stays 7 cycles.
- Reset mid-ACCUM: rst at T+2 -> no out_valid for that sample, out=0, gain=0, FSM accepts the next tick normally.
